// File: rtl/alu0_issue_queue_if.sv
// Dispatch, wakeup and issue signals between rename/dispatch, the ALU0 issue queue and ALU0.
// Latency: none, this is a bundle of wires.
// Backpressure: disp_rdy from the queue gates dispatch; issue has no backpressure.
interface alu0_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int NWK   = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             disp_vld;
  logic             disp_rdy;
  logic [4:0]       disp_op;
  logic [5:0]       disp_dest;
  logic [5:0]       disp_rob_id;
  logic [5:0]       disp_psrc1;
  logic [5:0]       disp_psrc2;
  logic             disp_rdy1;
  logic             disp_rdy2;
  logic [NWK-1:0]   wk_vld;
  logic [6*NWK-1:0] wk_pr;
  logic             iss_vld;
  logic [4:0]       iss_op;
  logic [5:0]       iss_dest;
  logic [5:0]       iss_rob_id;
  logic [5:0]       iss_psrc1;
  logic [5:0]       iss_psrc2;
  logic [CW-1:0]    count;

  // Dispatch/wakeup driver side (rename, result buses, bench).
  modport master (
    output flush, disp_vld, disp_op, disp_dest, disp_rob_id, disp_psrc1, disp_psrc2,
           disp_rdy1, disp_rdy2, wk_vld, wk_pr,
    input  disp_rdy, iss_vld, iss_op, iss_dest, iss_rob_id, iss_psrc1, iss_psrc2, count
  );

  // Issue queue side.
  modport slave (
    input  flush, disp_vld, disp_op, disp_dest, disp_rob_id, disp_psrc1, disp_psrc2,
           disp_rdy1, disp_rdy2, wk_vld, wk_pr,
    output disp_rdy, iss_vld, iss_op, iss_dest, iss_rob_id, iss_psrc1, iss_psrc2, count
  );
endinterface

// File: rtl/alu0_issue_queue.sv
// Compacting, age-ordered ALU0 issue queue with tag wakeup and oldest-ready select.
// Latency: ready dispatch -> iss_vld two cycles later; dependents issue back-to-back via self-wakeup.
// Backpressure: disp_rdy = registered count < DEPTH; a full queue refuses dispatch even in an issue cycle.
module alu0_issue_queue #(
  parameter int DEPTH = 8,
  parameter int NWK   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu0_issue_queue_if.slave q
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] op;
    logic [5:0] dest;
    logic [5:0] rob_id;
    logic [5:0] psrc1;
    logic       rdy1;
    logic [5:0] psrc2;
    logic       rdy2;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  // Entries with this cycle's wakeups applied; one extra zero slot feeds the top during compaction.
  entry_t        ent_wk [DEPTH+1];
  entry_t        disp_ent;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic          disp_rdy_w;
  logic          disp_acc;
  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  logic [5:0]    self_tag;

  logic          iss_vld_q, iss_vld_d;
  logic [4:0]    iss_op_q, iss_op_d;
  logic [5:0]    iss_dest_q, iss_dest_d;
  logic [5:0]    iss_rob_id_q, iss_rob_id_d;
  logic [5:0]    iss_psrc1_q, iss_psrc1_d;
  logic [5:0]    iss_psrc2_q, iss_psrc2_d;

  // True when tag matches the self-wakeup (selected entry's dest) or any active external port.
  function automatic logic wake_hit(input logic [5:0] tag, input logic s_vld, input logic [5:0] s_tag,
                                    input logic [NWK-1:0] wv, input logic [6*NWK-1:0] wp);
    logic hit;
    hit = s_vld && (s_tag == tag);
    for (int w = 0; w < NWK; w++) begin
      if (wv[w] && (wp[6*w +: 6] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign disp_rdy_w = (count_q < CW'(DEPTH));
  assign disp_acc   = q.disp_vld && disp_rdy_w;
  assign wr_idx     = count_q - CW'(sel_vld);
  assign self_tag   = ent_q[sel_idx].dest;

  // Oldest-ready select: scan from the top so the lowest ready index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // Apply this cycle's wakeup tags to every stored entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_wk[i] = ent_q[i];
      if (wake_hit(ent_q[i].psrc1, sel_vld, self_tag, q.wk_vld, q.wk_pr)) ent_wk[i].rdy1 = 1'b1;
      if (wake_hit(ent_q[i].psrc2, sel_vld, self_tag, q.wk_vld, q.wk_pr)) ent_wk[i].rdy2 = 1'b1;
    end
    ent_wk[DEPTH] = '0;
  end

  // Incoming bundle: busy-table ready, PR0 always ready, or caught by a same-cycle wakeup.
  always_comb begin
    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.op     = q.disp_op;
    disp_ent.dest   = q.disp_dest;
    disp_ent.rob_id = q.disp_rob_id;
    disp_ent.psrc1  = q.disp_psrc1;
    disp_ent.psrc2  = q.disp_psrc2;
    disp_ent.rdy1   = q.disp_rdy1 || (q.disp_psrc1 == 6'd0) ||
                      wake_hit(q.disp_psrc1, sel_vld, self_tag, q.wk_vld, q.wk_pr);
    disp_ent.rdy2   = q.disp_rdy2 || (q.disp_psrc2 == 6'd0) ||
                      wake_hit(q.disp_psrc2, sel_vld, self_tag, q.wk_vld, q.wk_pr);
  end

  // Queue next state: compact over the issued slot, append the dispatch, flush wipes everything.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (sel_vld && (i >= int'(sel_idx))) ? ent_wk[i+1] : ent_wk[i];
      if (disp_acc && (wr_idx == CW'(i))) ent_d[i] = disp_ent;
    end
    count_d = count_q + CW'(disp_acc) - CW'(sel_vld);
    if (q.flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end
  end

  // Issue bundle: load the selected entry, otherwise hold the data and drop valid.
  always_comb begin
    iss_vld_d    = sel_vld && !q.flush;
    iss_op_d     = iss_op_q;
    iss_dest_d   = iss_dest_q;
    iss_rob_id_d = iss_rob_id_q;
    iss_psrc1_d  = iss_psrc1_q;
    iss_psrc2_d  = iss_psrc2_q;
    if (iss_vld_d) begin
      iss_op_d     = ent_q[sel_idx].op;
      iss_dest_d   = ent_q[sel_idx].dest;
      iss_rob_id_d = ent_q[sel_idx].rob_id;
      iss_psrc1_d  = ent_q[sel_idx].psrc1;
      iss_psrc2_d  = ent_q[sel_idx].psrc2;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q      <= '0;
      iss_vld_q    <= 1'b0;
      iss_op_q     <= '0;
      iss_dest_q   <= '0;
      iss_rob_id_q <= '0;
      iss_psrc1_q  <= '0;
      iss_psrc2_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q      <= count_d;
      iss_vld_q    <= iss_vld_d;
      iss_op_q     <= iss_op_d;
      iss_dest_q   <= iss_dest_d;
      iss_rob_id_q <= iss_rob_id_d;
      iss_psrc1_q  <= iss_psrc1_d;
      iss_psrc2_q  <= iss_psrc2_d;
    end
  end

  assign q.disp_rdy   = disp_rdy_w;
  assign q.count      = count_q;
  assign q.iss_vld    = iss_vld_q;
  assign q.iss_op     = iss_op_q;
  assign q.iss_dest   = iss_dest_q;
  assign q.iss_rob_id = iss_rob_id_q;
  assign q.iss_psrc1  = iss_psrc1_q;
  assign q.iss_psrc2  = iss_psrc2_q;
endmodule

// File: tb/tb_alu0_issue_queue.sv
// Bench for alu0_issue_queue: scenario tasks plus an issue scoreboard.
// Latency: checks sampled 1 time unit after the rising edge; scoreboard pops on the falling edge.
// Backpressure: exercises full-queue refusal, flush and asynchronous reset.
module tb_alu0_issue_queue;
  localparam int DEPTH = 8;
  localparam int NWK   = 3;

  typedef struct packed {
    logic [4:0] op;
    logic [5:0] dest;
    logic [5:0] rob;
    logic [5:0] p1;
    logic [5:0] p2;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  alu0_issue_queue_if #(.DEPTH(DEPTH), .NWK(NWK)) q ();
  alu0_issue_queue #(.DEPTH(DEPTH), .NWK(NWK)) dut (.clk(clk), .rst_n(rst_n), .q(q));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    q.flush = 1'b0; q.disp_vld = 1'b0; q.disp_op = '0; q.disp_dest = '0; q.disp_rob_id = '0;
    q.disp_psrc1 = '0; q.disp_psrc2 = '0; q.disp_rdy1 = 1'b0; q.disp_rdy2 = 1'b0;
    q.wk_vld = '0; q.wk_pr = '0;
  endtask

  task automatic set_disp(input logic [4:0] op, input logic [5:0] dest, input logic [5:0] rob,
                          input logic [5:0] p1, input logic r1, input logic [5:0] p2, input logic r2);
    q.disp_vld = 1'b1; q.disp_op = op; q.disp_dest = dest; q.disp_rob_id = rob;
    q.disp_psrc1 = p1; q.disp_rdy1 = r1; q.disp_psrc2 = p2; q.disp_rdy2 = r2;
  endtask

  task automatic expect_iss(input logic [4:0] op, input logic [5:0] dest, input logic [5:0] rob,
                            input logic [5:0] p1, input logic [5:0] p2);
    exp_t e;
    e = '{op: op, dest: dest, rob: rob, p1: p1, p2: p2};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); tick(); tick();
    total++; if (q.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", q.count); end
    total++; if (q.disp_rdy !== 1'b1) begin bad++; $display("FAIL reset_disp_rdy got=%0b want=1", q.disp_rdy); end
    total++; if (q.iss_vld !== 1'b0) begin bad++; $display("FAIL reset_iss_vld got=%0b want=0", q.iss_vld); end
    total++; if ({q.iss_op, q.iss_dest, q.iss_rob_id, q.iss_psrc1, q.iss_psrc2} !== 29'd0) begin
      bad++; $display("FAIL reset_iss_data got=%h want=0", {q.iss_op, q.iss_dest, q.iss_rob_id, q.iss_psrc1, q.iss_psrc2});
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_basic();
    set_disp(5'd7, 6'd10, 6'd3, 6'd1, 1'b1, 6'd2, 1'b1); expect_iss(5'd7, 6'd10, 6'd3, 6'd1, 6'd2);
    tick(); q.disp_vld = 1'b0;
    total++; if (q.count !== 4'd1) begin bad++; $display("FAIL basic_count1 got=%0d want=1", q.count); end
    total++; if (q.iss_vld !== 1'b0) begin bad++; $display("FAIL basic_early_iss got=%0b want=0", q.iss_vld); end
    tick();
    total++; if (q.iss_vld !== 1'b1) begin bad++; $display("FAIL basic_iss_vld got=%0b want=1", q.iss_vld); end
    total++; if ({q.iss_op, q.iss_dest, q.iss_rob_id, q.iss_psrc1, q.iss_psrc2} !== {5'd7, 6'd10, 6'd3, 6'd1, 6'd2}) begin
      bad++; $display("FAIL basic_iss_data got=%0d/%0d/%0d/%0d/%0d want=7/10/3/1/2", q.iss_op, q.iss_dest, q.iss_rob_id, q.iss_psrc1, q.iss_psrc2);
    end
    total++; if (q.count !== 4'd0) begin bad++; $display("FAIL basic_count0 got=%0d want=0", q.count); end
    tick();
    total++; if (q.iss_vld !== 1'b0) begin bad++; $display("FAIL basic_iss_drop got=%0b want=0", q.iss_vld); end
    total++; if (q.iss_op !== 5'd7) begin bad++; $display("FAIL basic_iss_hold got=%0d want=7", q.iss_op); end
  endtask

  task automatic test_chain();
    // Consumer arrives while its producer is being selected.
    set_disp(5'd1, 6'd20, 6'd4, 6'd1, 1'b1, 6'd2, 1'b1); expect_iss(5'd1, 6'd20, 6'd4, 6'd1, 6'd2);
    tick();
    set_disp(5'd2, 6'd21, 6'd5, 6'd20, 1'b0, 6'd0, 1'b0); expect_iss(5'd2, 6'd21, 6'd5, 6'd20, 6'd0);
    tick(); q.disp_vld = 1'b0;
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd4) begin bad++; $display("FAIL chain_prod got=%0b/%0d want=1/4", q.iss_vld, q.iss_rob_id); end
    tick();
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd5) begin bad++; $display("FAIL chain_cons got=%0b/%0d want=1/5", q.iss_vld, q.iss_rob_id); end
    tick();
    // Producer and consumer both already queued.
    set_disp(5'd3, 6'd23, 6'd6, 6'd45, 1'b0, 6'd2, 1'b1); tick();
    set_disp(5'd4, 6'd24, 6'd7, 6'd23, 1'b0, 6'd2, 1'b1); tick(); q.disp_vld = 1'b0;
    q.wk_vld = 3'b001; q.wk_pr = {12'd0, 6'd45};
    expect_iss(5'd3, 6'd23, 6'd6, 6'd45, 6'd2); expect_iss(5'd4, 6'd24, 6'd7, 6'd23, 6'd2);
    tick(); q.wk_vld = '0; tick();
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd6) begin bad++; $display("FAIL chainq_prod got=%0b/%0d want=1/6", q.iss_vld, q.iss_rob_id); end
    tick();
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd7) begin bad++; $display("FAIL chainq_cons got=%0b/%0d want=1/7", q.iss_vld, q.iss_rob_id); end
    tick();
    total++; if (q.count !== 4'd0) begin bad++; $display("FAIL chain_count got=%0d want=0", q.count); end
  endtask

  task automatic test_age();
    set_disp(5'd3, 6'd30, 6'd8, 6'd40, 1'b0, 6'd1, 1'b1); tick();
    set_disp(5'd4, 6'd31, 6'd9, 6'd1, 1'b1, 6'd2, 1'b1); expect_iss(5'd4, 6'd31, 6'd9, 6'd1, 6'd2); tick();
    q.wk_vld = 3'b010; q.wk_pr = {6'd0, 6'd40, 6'd0}; expect_iss(5'd3, 6'd30, 6'd8, 6'd40, 6'd1);
    set_disp(5'd5, 6'd32, 6'd10, 6'd3, 1'b1, 6'd4, 1'b1); expect_iss(5'd5, 6'd32, 6'd10, 6'd3, 6'd4);
    tick(); idle_inputs();
    total++; if (q.iss_rob_id !== 6'd9 || q.count !== 4'd2) begin bad++; $display("FAIL age_first got=%0d/%0d want=9/2", q.iss_rob_id, q.count); end
    tick();
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd8) begin bad++; $display("FAIL age_oldest got=%0b/%0d want=1/8", q.iss_vld, q.iss_rob_id); end
    tick();
    total++; if (q.iss_rob_id !== 6'd10 || q.count !== 4'd0) begin bad++; $display("FAIL age_last got=%0d/%0d want=10/0", q.iss_rob_id, q.count); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(5'd6, 6'(12 + i), 6'(16 + i), 6'(50 + i), 1'b0, 6'd2, 1'b1); tick();
    end
    q.disp_vld = 1'b0;
    total++; if (q.count !== 4'd8 || q.disp_rdy !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%0b want=8/0", q.count, q.disp_rdy); end
    set_disp(5'd8, 6'd1, 6'd40, 6'd1, 1'b1, 6'd2, 1'b1); tick(); q.disp_vld = 1'b0;
    total++; if (q.count !== 4'd8) begin bad++; $display("FAIL full_ignore got=%0d want=8", q.count); end
    q.wk_vld = 3'b100; q.wk_pr = {6'd53, 12'd0}; expect_iss(5'd6, 6'd15, 6'd19, 6'd53, 6'd2);
    tick(); q.wk_vld = '0;
    set_disp(5'd8, 6'd1, 6'd41, 6'd1, 1'b1, 6'd2, 1'b1);
    total++; if (q.disp_rdy !== 1'b0) begin bad++; $display("FAIL full_no_credit got=%0b want=0", q.disp_rdy); end
    tick(); q.disp_vld = 1'b0;
    total++; if (q.count !== 4'd7 || q.disp_rdy !== 1'b1) begin bad++; $display("FAIL full_after_issue got=%0d/%0b want=7/1", q.count, q.disp_rdy); end
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd19) begin bad++; $display("FAIL full_issue got=%0b/%0d want=1/19", q.iss_vld, q.iss_rob_id); end
    q.flush = 1'b1; tick(); q.flush = 1'b0;
    total++; if (q.count !== 4'd0) begin bad++; $display("FAIL full_flush got=%0d want=0", q.count); end
  endtask

  task automatic test_wake_disp();
    set_disp(5'd9, 6'd22, 6'd24, 6'd5, 1'b1, 6'd33, 1'b0); q.wk_vld = 3'b001; q.wk_pr = {12'd0, 6'd33};
    expect_iss(5'd9, 6'd22, 6'd24, 6'd5, 6'd33);
    tick(); idle_inputs(); tick();
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd24) begin bad++; $display("FAIL wkdisp_issue got=%0b/%0d want=1/24", q.iss_vld, q.iss_rob_id); end
    total++; if (q.count !== 4'd0) begin bad++; $display("FAIL wkdisp_count got=%0d want=0", q.count); end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_disp(5'd10, 6'(26 + i), 6'(30 + i), 6'(60 + i), 1'b0, 6'd2, 1'b1); tick();
    end
    set_disp(5'd11, 6'd30, 6'd34, 6'd1, 1'b1, 6'd2, 1'b1); tick();
    set_disp(5'd12, 6'd31, 6'd35, 6'd1, 1'b1, 6'd2, 1'b1); q.flush = 1'b1;
    total++; if (q.count !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d want=5", q.count); end
    tick(); idle_inputs();
    total++; if (q.count !== 4'd0 || q.iss_vld !== 1'b0) begin bad++; $display("FAIL flush_post got=%0d/%0b want=0/0", q.count, q.iss_vld); end
    q.wk_vld = 3'b001; q.wk_pr = {12'd0, 6'd60}; tick(); idle_inputs(); tick(); tick();
    total++; if (q.iss_vld !== 1'b0 || q.count !== 4'd0) begin bad++; $display("FAIL flush_stale got=%0b/%0d want=0/0", q.iss_vld, q.count); end
    set_disp(5'd13, 6'd33, 6'd36, 6'd3, 1'b1, 6'd4, 1'b1); expect_iss(5'd13, 6'd33, 6'd36, 6'd3, 6'd4);
    tick(); q.disp_vld = 1'b0; tick();
    total++; if (q.iss_vld !== 1'b1 || q.iss_rob_id !== 6'd36) begin bad++; $display("FAIL flush_resume got=%0b/%0d want=1/36", q.iss_vld, q.iss_rob_id); end
    tick();
  endtask

  task automatic test_async_reset();
    set_disp(5'd14, 6'd40, 6'd37, 6'd61, 1'b0, 6'd2, 1'b1); tick();
    set_disp(5'd14, 6'd41, 6'd38, 6'd62, 1'b0, 6'd2, 1'b1); tick();
    set_disp(5'd15, 6'd42, 6'd39, 6'd1, 1'b1, 6'd2, 1'b1); tick(); q.disp_vld = 1'b0; tick();
    total++; if (q.iss_vld !== 1'b1 || q.count !== 4'd2) begin bad++; $display("FAIL arst_pre got=%0b/%0d want=1/2", q.iss_vld, q.count); end
    #1 rst_n = 1'b0; #1;
    total++; if (q.count !== 4'd0 || q.iss_vld !== 1'b0 || q.disp_rdy !== 1'b1 || q.iss_rob_id !== 6'd0) begin
      bad++; $display("FAIL arst_clear got=%0d/%0b/%0b/%0d want=0/0/1/0", q.count, q.iss_vld, q.disp_rdy, q.iss_rob_id);
    end
    tick(); rst_n = 1'b1; tick();
    q.wk_vld = 3'b011; q.wk_pr = {6'd0, 6'd62, 6'd61}; tick(); idle_inputs(); tick(); tick();
    total++; if (q.iss_vld !== 1'b0 || q.count !== 4'd0) begin bad++; $display("FAIL arst_stale got=%0b/%0d want=0/0", q.iss_vld, q.count); end
  endtask

  initial begin
    idle_inputs();
    fork
      begin : scoreboard
        exp_t got;
        exp_t want;
        forever begin
          @(negedge clk);
          if (rst_n && q.iss_vld === 1'b1) begin
            total++;
            got = '{op: q.iss_op, dest: q.iss_dest, rob: q.iss_rob_id, p1: q.iss_psrc1, p2: q.iss_psrc2};
            if (sb.size() == 0) begin
              bad++; $display("FAIL sb_unexpected got rob=%0d op=%0d want no issue", q.iss_rob_id, q.iss_op);
            end else begin
              want = sb.pop_front();
              if (got !== want) begin
                bad++;
                $display("FAIL sb_bundle got op=%0d dest=%0d rob=%0d p1=%0d p2=%0d want op=%0d dest=%0d rob=%0d p1=%0d p2=%0d",
                         got.op, got.dest, got.rob, got.p1, got.p2, want.op, want.dest, want.rob, want.p1, want.p2);
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic();
    test_chain();
    test_age();
    test_full();
    test_wake_disp();
    test_flush();
    test_async_reset();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
